// File: rtl/calc_rw_flow_ctrl_pkg.sv
// Shared types for the calculator read/write flow controller: state encodings and latched command.
package calc_ctrl_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_READMEM  = 3'd1;
  localparam logic [2:0] ST_WRITEMEM = 3'd2;
  localparam logic [2:0] ST_SAMPLE   = 3'd3;
  localparam logic [2:0] ST_TRANSFER = 3'd4;

  typedef enum logic [2:0] {
    CS_IDLE     = ST_IDLE,
    CS_READMEM  = ST_READMEM,
    CS_WRITEMEM = ST_WRITEMEM,
    CS_SAMPLE   = ST_SAMPLE,
    CS_TRANSFER = ST_TRANSFER
  } ctrl_state_e;

  typedef struct packed {
    logic mode;
    logic rw;
  } cmd_t;

  function automatic logic is_mem_state(input logic [2:0] s);
    return (s == ST_READMEM) || (s == ST_WRITEMEM);
  endfunction

endpackage

// File: rtl/calc_rw_flow_ctrl_if.sv
// Command/status bundle between decoder, flow controller, memory and serial transmitter.
interface calc_rw_flow_ctrl_if #(
  parameter int BEAT_W = 1
);
  logic              ValidCmd;
  logic              RW;
  logic              Mode;
  logic              Active;
  logic              TxDone;
  logic              AccessMem;
  logic              RWMem;
  logic              SampleData;
  logic              TxData;
  logic              Busy;
  logic [BEAT_W-1:0] BeatIdx;
  logic              CmdDrop;
  logic              Abort;
  logic              TimeoutErr;

  modport master (
    output ValidCmd, RW, Mode, Active, TxDone,
    input  AccessMem, RWMem, SampleData, TxData, Busy, BeatIdx, CmdDrop, Abort, TimeoutErr
  );

  modport slave (
    input  ValidCmd, RW, Mode, Active, TxDone,
    output AccessMem, RWMem, SampleData, TxData, Busy, BeatIdx, CmdDrop, Abort, TimeoutErr
  );
endinterface

// File: rtl/calc_rw_flow_ctrl_cnt.sv
// Loadable down counter with zero flag; saturates at zero, load wins over decrement.
module ctrl_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);
  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/calc_rw_flow_ctrl.sv
// Flow controller: memory beats -> sample -> transmit per command, one-deep pending slot, abort on Active loss.
// Read ValidCmd->TxData = MEM_LAT+2 cycles, direct = 2; CTRL_FLOW_TIMEOUT_EN adds a TRANSFER watchdog.
module calc_rw_flow_ctrl
  import calc_ctrl_pkg::*;
#(
  parameter int MEM_LAT     = 1,
  parameter int BURST_LEN   = 1,
  parameter int TIMEOUT_CYC = 256
) (
  input logic                Clk,
  input logic                Reset,
  calc_rw_flow_ctrl_if.slave bus
);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);
  localparam int LAT_W  = $clog2(MEM_LAT + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  logic [2:0]        state, state_nxt;
  cmd_t              cmd_q, cmd_nxt, cmd_in, src;
  cmd_t              pend_q, pend_nxt;
  logic              pend_vld, pend_vld_nxt, src_vld;
  logic [BEAT_W-1:0] beat, beat_nxt;
  logic              drop_q, drop_nxt, abort_q, abort_nxt, tmo_q, tmo_hit;
  logic              in_mem, lat_load, lat_zero, kill;

  assign in_mem   = is_mem_state(state);
  assign cmd_in   = {bus.Mode, bus.RW};
  assign kill     = (in_mem || (state == ST_SAMPLE)) && !bus.Active;
  assign lat_load = is_mem_state(state_nxt) && !in_mem;

  ctrl_down_counter #(.WIDTH(LAT_W)) u_lat_cnt (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (lat_load),
    .load_val (LAT_W'(MEM_LAT - 1)),
    .dec      (in_mem),
    .zero     (lat_zero)
  );

`ifdef CTRL_FLOW_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic in_xfer, tmo_zero;

  assign in_xfer = (state == ST_TRANSFER);

  // Reloaded every cycle outside TRANSFER and on TxDone, so each transfer gets a fresh budget.
  ctrl_down_counter #(.WIDTH(TMO_W)) u_tmo_cnt (
    .clk      (Clk),
    .rst_n    (Reset),
    .load     (!in_xfer || bus.TxDone),
    .load_val (TMO_W'(TIMEOUT_CYC - 1)),
    .dec      (in_xfer),
    .zero     (tmo_zero)
  );

  assign tmo_hit = in_xfer && !bus.TxDone && tmo_zero;
`else
  // No watchdog in this build; the expression folds to constant 0.
  assign tmo_hit = (TIMEOUT_CYC < 0);
`endif

  always_comb begin
    state_nxt    = state;
    cmd_nxt      = cmd_q;
    pend_vld_nxt = pend_vld;
    pend_nxt     = pend_q;
    beat_nxt     = beat;
    drop_nxt     = 1'b0;
    abort_nxt    = 1'b0;
    src_vld      = pend_vld || (bus.ValidCmd && bus.Active);
    src          = pend_vld ? pend_q : cmd_in;

    case (state)
      ST_IDLE: begin
        if (pend_vld) begin
          pend_vld_nxt = bus.ValidCmd && bus.Active;
          pend_nxt     = cmd_in;
        end
        if (src_vld) begin
          cmd_nxt  = src;
          beat_nxt = '0;
          if (!src.mode)   state_nxt = ST_SAMPLE;
          else if (src.rw) state_nxt = ST_WRITEMEM;
          else             state_nxt = ST_READMEM;
        end
      end
      ST_READMEM:  if (lat_zero) state_nxt = ST_SAMPLE;
      ST_WRITEMEM: if (lat_zero) state_nxt = ST_IDLE;
      ST_SAMPLE:   state_nxt = ST_TRANSFER;
      ST_TRANSFER: begin
        if (bus.TxDone) begin
          if (cmd_q.mode && !cmd_q.rw && (beat != LAST_BEAT)) begin
            beat_nxt  = beat + BEAT_W'(1);
            state_nxt = ST_READMEM;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    if ((state != ST_IDLE) && bus.ValidCmd) begin
      if (!pend_vld) begin
        pend_vld_nxt = 1'b1;
        pend_nxt     = cmd_in;
      end else begin
        drop_nxt = 1'b1;
      end
    end

    // Abort and timeout discard everything, including a command arriving this cycle.
    if (kill || tmo_hit) begin
      state_nxt    = ST_IDLE;
      pend_vld_nxt = 1'b0;
      drop_nxt     = 1'b0;
      abort_nxt    = kill;
    end

    if (state_nxt == ST_IDLE) beat_nxt = '0;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state    <= ST_IDLE;
      cmd_q    <= '0;
      pend_vld <= 1'b0;
      pend_q   <= '0;
      beat     <= '0;
      drop_q   <= 1'b0;
      abort_q  <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      cmd_q    <= cmd_nxt;
      pend_vld <= pend_vld_nxt;
      pend_q   <= pend_nxt;
      beat     <= beat_nxt;
      drop_q   <= drop_nxt;
      abort_q  <= abort_nxt;
      tmo_q    <= tmo_hit;
    end
  end

  assign bus.AccessMem  = in_mem;
  assign bus.RWMem      = (state == ST_WRITEMEM);
  assign bus.SampleData = (state == ST_SAMPLE);
  assign bus.TxData     = (state == ST_TRANSFER);
  assign bus.Busy       = (state != ST_IDLE);
  assign bus.BeatIdx    = beat;
  assign bus.CmdDrop    = drop_q;
  assign bus.Abort      = abort_q;
  assign bus.TimeoutErr = tmo_q;
endmodule

// File: tb/tb_calc_rw_flow_ctrl.sv
// Bench for calc_rw_flow_ctrl: directed scenarios then random traffic against a cycle-level behavioural model.
module tb_calc_rw_flow_ctrl;
  localparam int MEM_LAT     = 3;
  localparam int BURST_LEN   = 4;
  localparam int TIMEOUT_CYC = 8;
  localparam int BW          = $clog2(BURST_LEN + 1);
`ifdef CTRL_FLOW_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_rw_flow_ctrl_if #(.BEAT_W(BW)) bus ();

  calc_rw_flow_ctrl #(
    .MEM_LAT     (MEM_LAT),
    .BURST_LEN   (BURST_LEN),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc, n_smp, n_tx;

  // Model: phase 0 idle, 1 memory beat, 2 sample, 3 transfer.
  int ph = 0, mem_left = 0, beat = 0, xfer_cyc = 0;
  bit m_wr, m_rd, m_drop, m_abort, m_tmo;
  bit [1:0] pq[$];
  logic [7+BW:0] obs_v, exp_v;

  function automatic logic [7+BW:0] model_out();
    return {ph == 1, (ph == 1) && m_wr, ph == 2, ph == 3, ph != 0, BW'(beat), m_drop, m_abort, m_tmo};
  endfunction

  task automatic start_cmd(input bit [1:0] c);
    beat = 0;
    m_wr = c[1] && c[0];
    m_rd = c[1] && !c[0];
    if (c[1]) begin ph = 1; mem_left = MEM_LAT; end
    else ph = 2;
  endtask

  task automatic model_step(input bit r, input bit vc, input bit rw, input bit mode, input bit act, input bit txd);
    bit aborting, timed;
    m_drop = 0; m_abort = 0; m_tmo = 0;
    if (!r) begin ph = 0; beat = 0; pq.delete(); return; end
    if (ph == 0) begin
      if (pq.size() != 0) begin
        start_cmd(pq.pop_front());
        if (vc && act) pq.push_back({mode, rw});
      end else if (vc && act) begin
        start_cmd({mode, rw});
      end
      return;
    end
    aborting = (ph != 3) && !act;
    timed = (ph == 3) && !txd && TMO_EN && (xfer_cyc + 1 >= TIMEOUT_CYC);
    if (aborting || timed) begin
      ph = 0; beat = 0; pq.delete(); m_abort = aborting; m_tmo = timed;
      return;
    end
    if (vc) begin
      if (pq.size() == 0) pq.push_back({mode, rw});
      else m_drop = 1;
    end
    case (ph)
      1: begin
        mem_left--;
        if (mem_left == 0) begin
          if (m_wr) begin ph = 0; beat = 0; end
          else ph = 2;
        end
      end
      2: begin ph = 3; xfer_cyc = 0; end
      default: begin
        if (txd) begin
          if (m_rd && beat < BURST_LEN - 1) begin beat++; ph = 1; mem_left = MEM_LAT; end
          else begin ph = 0; beat = 0; end
        end else begin
          xfer_cyc++;
        end
      end
    endcase
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs for one cycle, advance model, then compare at the following negedge.
  task automatic tick(input bit r, input bit vc, input bit rw, input bit mode, input bit act, input bit txd);
    rst_n = r; bus.ValidCmd = vc; bus.RW = rw; bus.Mode = mode; bus.Active = act; bus.TxDone = txd;
    model_step(r, vc, rw, mode, act, txd);
    @(posedge clk);
    @(negedge clk);
    obs_v = {bus.AccessMem, bus.RWMem, bus.SampleData, bus.TxData, bus.Busy, bus.BeatIdx,
             bus.CmdDrop, bus.Abort, bus.TimeoutErr};
    exp_v = model_out();
    checks++;
    assert (obs_v === exp_v) else begin
      failures++;
      $error("FAIL outputs cyc=%0d observed=%h expected=%h", cyc, obs_v, exp_v);
    end
    if (bus.AccessMem === 1'b1)  n_acc++;
    if (bus.SampleData === 1'b1) n_smp++;
    if (bus.TxData === 1'b1)     n_tx++;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, dones, guard;
    bit r, vc, rw, md, act, txd;
    bus.ValidCmd = 0; bus.RW = 0; bus.Mode = 0; bus.Active = 0; bus.TxDone = 0;
    @(negedge clk);

    // Reset state
    tick(0, 0, 0, 0, 1, 0);
    tick(0, 1, 0, 1, 1, 1);
    chk("reset_outputs", 32'(obs_v), 32'd0);

    // Burst read: latency, TxDone 4 cycles after TxData rises, then remaining beats
    n_acc = 0; n_smp = 0; n_tx = 0;
    tick(1, 1, 0, 1, 1, 0);
    lat = 1;
    while (bus.TxData !== 1'b1 && lat < 30) begin tick(1, 0, 0, 0, 1, 0); lat++; end
    chk("read_latency", lat, MEM_LAT + 2);
    repeat (3) tick(1, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 1);
    dones = 1; guard = 0;
    while (bus.Busy === 1'b1 && guard < 100) begin
      if (bus.TxData === 1'b1) begin dones++; tick(1, 0, 0, 0, 1, 1); end
      else tick(1, 0, 0, 0, 1, 0);
      guard++;
    end
    chk("burst_beats", dones, BURST_LEN);
    chk("burst_accessmem_cycles", n_acc, BURST_LEN * MEM_LAT);
    chk("burst_sample_cycles", n_smp, BURST_LEN);
    chk("burst_txdata_cycles", n_tx, 4 + BURST_LEN - 1);

    // Direct command with TxDone held high: single beat, latency 2
    n_tx = 0;
    tick(1, 1, 0, 0, 1, 1);
    lat = 1;
    while (bus.TxData !== 1'b1 && lat < 30) begin tick(1, 0, 0, 0, 1, 1); lat++; end
    chk("direct_latency", lat, 2);
    tick(1, 0, 0, 0, 1, 1);
    chk("direct_single_beat_busy", bus.Busy, 0);
    chk("direct_txdata_cycles", n_tx, 1);
    tick(1, 0, 0, 0, 1, 0);

    // Write plus two commands while busy: first queued, second dropped
    tick(1, 1, 1, 1, 1, 0);
    chk("write_rwmem", bus.RWMem, 1);
    tick(1, 1, 0, 0, 1, 0);
    tick(1, 1, 1, 1, 1, 0);
    chk("cmd_drop_pulse", bus.CmdDrop, 1);
    tick(1, 0, 0, 0, 1, 0);
    chk("write_done_idle", bus.Busy, 0);
    tick(1, 0, 0, 0, 1, 0);
    chk("queued_cmd_started", bus.SampleData, 1);
    tick(1, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 1);

    // Active dropped in the second READMEM cycle with a command pending
    tick(1, 1, 0, 1, 1, 0);
    tick(1, 1, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0);
    chk("abort_pulse_outputs", {bus.Abort, bus.Busy, bus.AccessMem}, 3'b100);
    tick(1, 0, 0, 0, 1, 0);
    chk("abort_slot_flushed", bus.Busy, 0);

    // TxDone never asserted
    tick(1, 1, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 0);
    repeat (TIMEOUT_CYC) tick(1, 0, 0, 0, 1, 0);
`ifdef CTRL_FLOW_TIMEOUT_EN
    chk("timeout_pulse", {bus.TimeoutErr, bus.TxData, bus.Busy}, 3'b100);
`else
    chk("no_timeout_txdata_held", {bus.TimeoutErr, bus.TxData}, 2'b01);
    tick(1, 0, 0, 0, 1, 1);
`endif

    // Reset during TRANSFER
    tick(1, 1, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 1, 0);
    tick(0, 0, 0, 0, 1, 0);
    chk("reset_mid_transfer", 32'(obs_v), 32'd0);
    tick(1, 0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      r   = ($urandom_range(0, 199) != 0);
      vc  = ($urandom_range(0, 3) == 0);
      rw  = ($urandom_range(0, 1) == 1);
      md  = ($urandom_range(0, 1) == 1);
      act = ($urandom_range(0, 9) != 0);
      txd = ($urandom_range(0, 3) == 0);
      tick(r, vc, rw, md, act, txd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
